// File: rtl/fb_writer.sv
// Framebuffer writer: streams a pixel source into y*WIDTH+x addresses, or fills the buffer.
// Optional fill (CLEAR) support is compiled in when FB_WR_CLEAR_EN is defined.
//
// state  | meaning
// IDLE   | waiting for start (or clear); counters held at 0
// STREAM | accepting one pixel per valid beat, writing it one cycle later
// CLEAR  | writing the latched clear colour to every address, one per cycle
module fb_writer #(
    parameter int WIDTH  = 320,
    parameter int HEIGHT = 240
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        clear,
    input  logic [11:0] clear_color,
    input  logic        pix_valid,
    input  logic [11:0] pix_data,
    output logic        pix_ready,
    output logic        wr_en,
    output logic [16:0] wr_addr,
    output logic [11:0] wr_data,
    output logic        busy,
    output logic        frame_done
);

    localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int YW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam logic [XW-1:0] X_LAST = XW'(WIDTH - 1);
    localparam logic [YW-1:0] Y_LAST = YW'(HEIGHT - 1);

    typedef enum logic [1:0] {IDLE, STREAM, CLEAR} state_t;

    state_t        state;
    logic [XW-1:0] x;
    logic [YW-1:0] y;
    logic [16:0]   addr;
    logic          adv;
    logic          last_pix;
    logic [11:0]   adv_data;

    assign pix_ready = (state == STREAM);
    assign busy      = (state != IDLE);
    assign last_pix  = (x == X_LAST) && (y == Y_LAST);

`ifdef FB_WR_CLEAR_EN
    logic [11:0] fill;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            fill <= '0;
        end else if (state == IDLE && clear) begin
            fill <= clear_color;
        end
    end

    assign adv      = (state == CLEAR) || (state == STREAM && pix_valid);
    assign adv_data = (state == CLEAR) ? fill : pix_data;
`else
    logic unused_clear;
    assign unused_clear = ^{clear, clear_color};
    assign adv          = (state == STREAM) && pix_valid;
    assign adv_data     = pix_data;
`endif

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= IDLE;
            x          <= '0;
            y          <= '0;
            addr       <= '0;
            wr_en      <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            frame_done <= 1'b0;
        end else begin
            wr_en      <= 1'b0;
            frame_done <= 1'b0;
            if (state == IDLE) begin
                x    <= '0;
                y    <= '0;
                addr <= '0;
`ifdef FB_WR_CLEAR_EN
                if (clear)
                    state <= CLEAR;
                else
`endif
                if (start)
                    state <= STREAM;
            end else if (adv) begin
                wr_en   <= 1'b1;
                wr_addr <= addr;
                wr_data <= adv_data;
                // Address walks linearly alongside x/y so no y*WIDTH multiply is needed.
                if (last_pix) begin
                    x          <= '0;
                    y          <= '0;
                    addr       <= '0;
                    frame_done <= 1'b1;
                    state      <= IDLE;
                end else begin
                    addr <= addr + 17'd1;
                    if (x == X_LAST) begin
                        x <= '0;
                        y <= y + 1'b1;
                    end else begin
                        x <= x + 1'b1;
                    end
                end
            end
        end
    end

endmodule

// File: doc/fb_writer.md
FB_WRITER -- requirements
Module: fb_writer

Interface
REQ-001 Parameter WIDTH, default 320, pixels per line.
REQ-002 Parameter HEIGHT, default 240, lines per frame; WIDTH*HEIGHT SHALL be at most 131072.
REQ-003 clk  in  1  system clock, 25 MHz domain; one clock, all logic on its rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-low.
REQ-005 start  in  1  single-cycle pulse; begin streaming a frame at address 0.
REQ-006 clear  in  1  single-cycle pulse; fill the whole buffer with clear_color.
REQ-007 clear_color  in  12  fill colour, {R[11:8],G[7:4],B[3:0]}, sampled on the accepted clear pulse.
REQ-008 pix_valid  in  1  source has a pixel.
REQ-009 pix_data  in  12  pixel, {R,G,B} 4 bits each.
REQ-010 pix_ready  out  1  writer accepts a pixel this cycle.
REQ-011 wr_en  out  1  framebuffer write strobe.
REQ-012 wr_addr  out  17  framebuffer address, y*WIDTH+x.
REQ-013 wr_data  out  12  framebuffer write data.
REQ-014 busy  out  1  high in any state other than IDLE.
REQ-015 frame_done  out  1  one-cycle pulse when the last address of a frame or clear is written.

Function
REQ-016 The FSM SHALL have the states IDLE, STREAM and CLEAR.
REQ-017 IDLE: clear -> CLEAR; start -> STREAM; if both are high in the same cycle, clear SHALL win and start is dropped.
REQ-018 On entry to STREAM or CLEAR, the x, y and address counters SHALL be 0.
REQ-019 STREAM: pix_ready = 1 combinationally; in IDLE and CLEAR pix_ready = 0.
REQ-020 A beat is accepted when pix_valid & pix_ready; stalls (pix_valid=0) hold all counters.
REQ-021 For an accepted beat, the next cycle SHALL show wr_en=1, wr_addr=current address, wr_data=pix_data; latency 1 cycle.
REQ-022 Without an accepted beat (or write in CLEAR), wr_en SHALL be 0 that cycle; wr_addr and wr_data hold their last values.
REQ-023 Counter advance: x+1; at x=WIDTH-1, x wraps to 0 and y+1; the address SHALL increment by 1 with no multiplier, and SHALL always equal y*WIDTH+x.
REQ-024 Accepting pixel (WIDTH-1, HEIGHT-1) SHALL return the FSM to IDLE.
REQ-025 frame_done SHALL pulse in the same cycle as that final write.
REQ-026 CLEAR: one write per cycle, address 0..WIDTH*HEIGHT-1, data = latched clear_color.
REQ-027 After the last clear write, frame_done SHALL pulse with that write and the FSM SHALL return to IDLE.
REQ-028 A clear of the full default frame therefore takes 76800 cycles.
REQ-029 start or clear asserted while busy SHALL be ignored, with no effect on counters or state.
REQ-030 Back-to-back frames: a start in the cycle after frame_done SHALL be accepted normally.

Reset
REQ-031 On rst=0, immediately and asynchronously: state=IDLE; x, y and address = 0; wr_en=0; wr_addr=0; wr_data=0; frame_done=0; busy=0; pix_ready=0.
REQ-032 A reset mid-frame or mid-clear SHALL abort the operation; no write or frame_done SHALL follow until a new start or clear.
REQ-033 The first start SHALL be honoured on the first clock edge after rst deasserts.

Configuration
REQ-034 Macro FB_WR_CLEAR_EN, when defined, SHALL include the CLEAR state and the fill behaviour described above.
REQ-035 When FB_WR_CLEAR_EN is undefined, the clear and clear_color ports remain but are ignored, CLEAR is unreachable, and start behaves identically.

Verification
REQ-036 Reset then start, then 76800 beats with pix_data=address[11:0] and pix_valid always 1 -> 76800 writes, wr_addr 0..76799 in order, wr_data matches, frame_done exactly once at wr_addr=76799.
REQ-037 start, then pixels 0..319 with random pix_valid gaps -> writes only on beats, no duplicates; pixel 320 -> wr_addr=320 (x=0, y=1).
REQ-038 clear with clear_color=12'hF00, FB_WR_CLEAR_EN defined -> 76800 consecutive writes of 12'hF00, busy high for 76800 cycles, pix_ready=0 throughout; with the macro undefined -> no writes, busy stays 0.
REQ-039 start and clear in the same cycle -> CLEAR entered; start and clear while STREAM at address 100 -> ignored, next write is address 101.
REQ-040 rst=0 at address 5000 mid-frame -> wr_en and busy drop immediately; after release, start plus one beat -> write at wr_addr=0.
